// File: rtl/bram_burst_reader_pkg.sv
// ---------------------------------------------------------------------------
// bram_burst_reader_pkg
//   Shared definitions for the BRAM burst reader:
//     - state_t : FSM state encodings (IDLE=0, ISSUE=1, DRAIN=2, DONE=3)
//     - RD_LAT  : BRAM read latency in cycles (en -> regce -> data)
//     - tok_count() : number of set bits in the read-token shift register
// ---------------------------------------------------------------------------
package bram_burst_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int RD_LAT = 2;

    function automatic logic [3:0] tok_count(input logic [RD_LAT-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/bram_rd_fifo.sv
// ---------------------------------------------------------------------------
// bram_rd_fifo
//   Synchronous FIFO used as the skid buffer behind the BRAM read pipe.
//   Head word is presented combinationally (first-word fall-through).
//   Simultaneous push and pop on a full FIFO is legal; count is unchanged.
// Ports
//   clk_i        in   clock
//   rstn_i       in   synchronous active-low reset
//   push_i       in   write push_data_i
//   push_data_i  in   WIDTH  word to store
//   pop_i        in   drop the head word
//   head_o       out  WIDTH  oldest stored word
//   count_o      out  occupancy
//   full_o       out  count == DEPTH
//   empty_o      out  count == 0
// ---------------------------------------------------------------------------
module bram_rd_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [AW:0]      count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full_o    = (r_count == (AW+1)'(DEPTH));
    assign empty_o   = (r_count == '0);
    assign count_o   = r_count;
    assign head_o    = r_mem[r_rd_ptr];
    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bram_burst_reader.sv
// ---------------------------------------------------------------------------
// bram_burst_reader
//   Read-side initiator for one port of a 2-cycle-latency BRAM. Takes a
//   (base, len) burst command, issues reads under a credit limit and streams
//   the words out through a skid FIFO as valid/ready with a last marker.
//   Optional feature macro: BRAM_RD_PERF_EN adds perf_stall_o, a saturating
//   count of stalled-output cycles during a burst.
// Ports
//   clk_i, rstn_i          clock, synchronous active-low reset
//   start_i                burst strobe (ignored while busy_o)
//   base_addr_i, len_i     first address, word count (0..2**ADDR_LINES)
//   busy_o, done_o         burst in progress, 1-cycle completion pulse
//   bram_addr_o/en_o/regce_o  registered BRAM port controls
//   bram_dout_i            BRAM read data
//   m_data_o/valid_o/ready_i/last_o  output stream
//   perf_stall_o           (BRAM_RD_PERF_EN only) stall cycle counter
//
//   state  | meaning
//   IDLE   | waiting for start_i
//   ISSUE  | issuing reads while credit allows
//   DRAIN  | all reads issued, waiting for the last beat to be accepted
//   DONE   | raise done_o, drop busy_o, return to IDLE
// ---------------------------------------------------------------------------
module bram_burst_reader
    import bram_burst_reader_pkg::*;
#(
    parameter int RAM_WIDTH  = 32,
    parameter int ADDR_LINES = 4,
    parameter int LEN_BITS   = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  start_i,
    input  logic [ADDR_LINES-1:0] base_addr_i,
    input  logic [LEN_BITS-1:0]   len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_LINES-1:0] bram_addr_o,
    output logic                  bram_en_o,
    output logic                  bram_regce_o,
    input  logic [RAM_WIDTH-1:0]  bram_dout_i,
    output logic [RAM_WIDTH-1:0]  m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
`ifdef BRAM_RD_PERF_EN
    output logic [15:0]           perf_stall_o,
`endif
    output logic                  m_last_o
);

    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = CW + 1;

    state_t                r_state;
    logic [ADDR_LINES-1:0] r_ptr;
    logic [LEN_BITS-1:0]   r_remaining;
    logic                  r_en;
    logic                  r_en_last;
    logic [RD_LAT-1:0]     r_tok;
    logic [RD_LAT-1:0]     r_tok_last;

    logic [RAM_WIDTH:0]    w_head;
    logic [CW-1:0]         w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_head_last;
    logic [OCC_W-1:0]      w_occ;
    logic                  w_credit;
    logic                  w_issue;

    bram_rd_fifo #(
        .WIDTH (RAM_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .push_i      (r_tok[RD_LAT-1]),
        .push_data_i ({r_tok_last[RD_LAT-1], bram_dout_i}),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .count_o     (w_count),
        .full_o      (w_full),
        .empty_o     (w_empty)
    );

    assign w_pop       = !w_empty && m_ready_i;
    assign w_head_last = w_head[RAM_WIDTH];
    assign m_valid_o   = !w_empty;
    // Gate the head so outputs are 0 while nothing is held (e.g. after reset).
    assign m_data_o    = w_empty ? '0 : w_head[RAM_WIDTH-1:0];
    assign m_last_o    = !w_empty && w_head_last;
    assign bram_en_o    = r_en;
    assign bram_regce_o = r_tok[0];

    // Every issued read still in the pipe owns a FIFO slot; a pop this cycle
    // frees one, which keeps back-to-back issue going at full throughput.
    always_comb begin
        w_occ    = OCC_W'(w_count) + OCC_W'(r_en) + OCC_W'(tok_count(r_tok))
                   - OCC_W'(w_pop);
        w_credit = (w_occ < OCC_W'(FIFO_DEPTH)) && !(w_full && !w_pop);
        w_issue  = (r_state == ST_ISSUE) && w_credit;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_remaining <= '0;
            r_en        <= 1'b0;
            r_en_last   <= 1'b0;
            r_tok       <= '0;
            r_tok_last  <= '0;
            bram_addr_o <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            r_en       <= w_issue;
            r_en_last  <= w_issue && (r_remaining == LEN_BITS'(1));
            r_tok      <= {r_tok[RD_LAT-2:0], r_en};
            r_tok_last <= {r_tok_last[RD_LAT-2:0], r_en_last};

            case (r_state)
                ST_IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        r_ptr       <= base_addr_i;
                        r_remaining <= len_i;
                        busy_o      <= 1'b1;
                        r_state     <= (len_i == '0) ? ST_DONE : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_issue) begin
                        bram_addr_o <= r_ptr;
                        r_ptr       <= r_ptr + 1'b1;
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining == LEN_BITS'(1)) r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // The last-flagged beat is the final word; once it leaves,
                    // nothing else is in flight or buffered.
                    if (w_pop && w_head_last) begin
                        done_o  <= 1'b1;
                        busy_o  <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Entered with done_o already set from DRAIN; a zero-length
                    // burst arrives with it clear and raises it here first.
                    if (done_o) begin
                        done_o  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef BRAM_RD_PERF_EN
    logic [15:0] r_perf;
    assign perf_stall_o = r_perf;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_perf <= '0;
        end else if (r_state == ST_IDLE && start_i) begin
            r_perf <= '0;
        end else if (busy_o && m_valid_o && !m_ready_i && r_perf != 16'hFFFF) begin
            r_perf <= r_perf + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bram_burst_reader.sv
// Bench for bram_burst_reader with a 2-cycle-latency BRAM model preloaded
// with mem[i] = A000_0000 + i. Expected beats go into a queue when a burst
// is started and are compared against the stream as it is produced.
module tb_bram_burst_reader;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  base_addr = '0;
    logic [4:0]  len = '0;
    logic        busy, done;
    logic [3:0]  bram_addr;
    logic        bram_en, bram_regce;
    logic [31:0] bram_dout = '0;
    logic [31:0] m_data;
    logic        m_valid, m_last;
    logic        m_ready = 1'b1;
`ifdef BRAM_RD_PERF_EN
    logic [15:0] perf_stall;
`endif

    always #5 clk = ~clk;

    bram_burst_reader dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .start_i      (start),
        .base_addr_i  (base_addr),
        .len_i        (len),
        .busy_o       (busy),
        .done_o       (done),
        .bram_addr_o  (bram_addr),
        .bram_en_o    (bram_en),
        .bram_regce_o (bram_regce),
        .bram_dout_i  (bram_dout),
        .m_data_o     (m_data),
        .m_valid_o    (m_valid),
        .m_ready_i    (m_ready),
`ifdef BRAM_RD_PERF_EN
        .perf_stall_o (perf_stall),
`endif
        .m_last_o     (m_last)
    );

    // 2-cycle-latency BRAM: address register stage, then output register.
    logic [31:0] mem [16];
    logic [31:0] bram_q1 = '0;
    initial for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 + i;
    always @(posedge clk) begin
        if (bram_en)    bram_q1   <= mem[bram_addr];
        if (bram_regce) bram_dout <= bram_q1;
    end

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   xfer_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc = 0;
    int   en_cnt = 0, done_cnt = 0, beat_cnt = 0, valid_cnt = 0;
    int   done_cyc = -1, last_xfer_cyc = -1, first_valid_cyc = -1;
    int   start_cyc = 0, done0 = 0, beats0 = 0, en0 = 0, valid0 = 0;
    int   ready_mode = 0;   // 0: always ready, 1: random, 2: never ready

    task automatic check_val(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            if (bram_en) en_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (m_valid) begin
                valid_cnt++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check_val("unexpected_beat", {32'h0, m_data}, 64'hDEAD);
                end else begin
                    check_val("data", {32'h0, m_data}, {32'h0, exp_q[0].data});
                    check_val("last", {63'h0, m_last}, {63'h0, exp_q[0].last});
                    if (m_ready) begin
                        if (exp_q[0].last) last_xfer_cyc = cyc;
                        void'(exp_q.pop_front());
                        xfer_q.push_back(cyc);
                        beat_cnt++;
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input logic [3:0] b, input logic [4:0] l);
        exp_t e;
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = b;
        len = l;
        start_cyc = cyc;
        first_valid_cyc = -1;
        done0 = done_cnt;
        beats0 = beat_cnt;
        en0 = en_cnt;
        valid0 = valid_cnt;
        xfer_q.delete();
        for (int i = 0; i < int'(l); i++) begin
            e.data = 32'hA000_0000 + ((int'(b) + i) % 16);
            e.last = (i == int'(l) - 1);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int l);
        for (int i = 0; i < 300; i++) begin
            if (done_cnt > done0) break;
            tick(1);
        end
        if (done_cnt == done0) check_val("done_timeout", 64'd0, 64'd1);
        tick(4);
        check_val("done_once", 64'(done_cnt - done0), 64'd1);
        check_val("beat_count", 64'(beat_cnt - beats0), 64'(l));
        check_val("queue_empty", 64'(exp_q.size()), 64'd0);
        check_val("busy_after", {63'h0, busy}, 64'd0);
    endtask

    initial begin
        int bad;
        int d_before, v_before;

        // Reset state
        tick(3);
        check_val("rst_busy",  {63'h0, busy},       64'd0);
        check_val("rst_done",  {63'h0, done},       64'd0);
        check_val("rst_addr",  {60'h0, bram_addr},  64'd0);
        check_val("rst_en",    {63'h0, bram_en},    64'd0);
        check_val("rst_regce", {63'h0, bram_regce}, 64'd0);
        check_val("rst_valid", {63'h0, m_valid},    64'd0);
        check_val("rst_last",  {63'h0, m_last},     64'd0);
        check_val("rst_data",  {32'h0, m_data},     64'd0);
        rstn = 1'b1;
        tick(2);

        // 1: full-length burst, always ready
        ready_mode = 0;
        tick(2);
        start_burst(4'd0, 5'd16);
        wait_done(16);
        check_val("first_valid_latency", 64'(first_valid_cyc - (start_cyc + 1)), 64'd4);
        bad = 0;
        for (int i = 1; i < xfer_q.size(); i++)
            if (xfer_q[i] - xfer_q[i-1] != 1) bad++;
        check_val("back_to_back_gaps", 64'(bad), 64'd0);
        check_val("done_after_last", 64'(done_cyc - last_xfer_cyc), 64'd1);

        // 2: address wrap
        start_burst(4'd14, 5'd4);
        wait_done(4);

        // 3: output held off; issue must stop at FIFO depth
        ready_mode = 2;
        tick(3);
        start_burst(4'd0, 5'd8);
        tick(9);
        check_val("credit_en_pulses", 64'(en_cnt - en0), 64'd4);
        check_val("stalled_valid", {63'h0, m_valid}, 64'd1);
        ready_mode = 0;
        wait_done(8);

        // 4: random backpressure
        ready_mode = 1;
        tick(2);
        start_burst(4'd0, 5'd16);
        wait_done(16);
        ready_mode = 0;
        tick(2);

        // 5: zero-length burst
        start_burst(4'd5, 5'd0);
        wait_done(0);
        check_val("len0_done_delay", 64'(done_cyc - start_cyc), 64'd2);
        check_val("len0_no_en", 64'(en_cnt - en0), 64'd0);
        check_val("len0_no_valid", 64'(valid_cnt - valid0), 64'd0);

        // 6: reset mid-burst, then a fresh burst
        start_burst(4'd0, 5'd16);
        tick(6);
        d_before = done_cnt;
        rstn = 1'b0;
        tick(2);
        exp_q.delete();
        check_val("midrst_valid", {63'h0, m_valid}, 64'd0);
        check_val("midrst_busy",  {63'h0, busy},    64'd0);
        check_val("midrst_en",    {63'h0, bram_en}, 64'd0);
        rstn = 1'b1;
        v_before = valid_cnt;
        tick(8);
        check_val("midrst_no_done",  64'(done_cnt - d_before),  64'd0);
        check_val("midrst_no_stale", 64'(valid_cnt - v_before), 64'd0);
        start_burst(4'd3, 5'd2);
        wait_done(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
